matmul_apb_requester: RTL and testbench

- APB initiator that drives the matmul accelerator's APB completer port; the golden checker monitors the same bus.
- Converts a valid/ready command stream (write operand/control registers, read result registers) into APB SETUP/ACCESS transfers.
- Returns one response per command; read responses carry PRDATA.
- Used by testbench sequencers and by the on-chip loader that feeds and drains the matmul.

---
 rtl/matmul_apb_pkg.sv | 22 ++
 rtl/matmul_apb_watchdog.sv | 39 +++
 rtl/matmul_apb_requester.sv | 188 ++++++++++++++++++
 tb/tb_matmul_apb_requester.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_apb_pkg.sv
// Shared types for the matmul APB requester: FSM state encoding and the latched command.
package matmul_apb_pkg;

    localparam int APB_BUS_WIDTH  = 32;
    localparam int APB_ADDR_WIDTH = 16;
    localparam int STRB_WIDTH     = APB_BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_BUS_WIDTH-1:0]  wdata;
        logic [STRB_WIDTH-1:0]     strb;
    } apb_cmd_t;

endpackage

// File: rtl/matmul_apb_watchdog.sv
// ACCESS-phase watchdog for the matmul APB requester; only instantiated when
// MATMUL_APB_TIMEOUT_EN is defined.
module matmul_apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    // Fires in the cycle that would be the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    assign expired_o = count_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/matmul_apb_requester.sv
// APB initiator for the matmul completer: one valid/ready command in, one response out.
// Optional ACCESS watchdog enabled by defining MATMUL_APB_TIMEOUT_EN.
module matmul_apb_requester
    import matmul_apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BUS_WIDTH      = APB_BUS_WIDTH,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int MAX_DIM        = BUS_WIDTH / DATA_WIDTH,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]   cmd_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] cmd_strb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_write_o,
    output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [ADDR_WIDTH-1:0]  paddr_o,
    output logic [BUS_WIDTH-1:0]   pwdata_o,
    output logic [BUS_WIDTH/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [BUS_WIDTH-1:0]   prdata_i,
    output logic [CNT_WIDTH-1:0]   rd_count_o,
    output logic [CNT_WIDTH-1:0]   wr_count_o
);

    if (MAX_DIM * DATA_WIDTH > BUS_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("matmul_apb_requester: inconsistent parameter set");
    end

    state_t               state_q, state_d;
    apb_cmd_t             cmd_q, cmd_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                 cmd_accept;
    logic                 timeout_hit;

`ifdef MATMUL_APB_TIMEOUT_EN
    logic wd_expired;

    matmul_apb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q == SETUP),
        .count_i  ((state_q == ACCESS) && !pready_i),
        .expired_o(wd_expired)
    );

    assign timeout_hit = wd_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // Draining a response frees the requester in the same cycle, allowing back-to-back accepts.
    assign cmd_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;

        // Reads never present write data or strobes on the bus.
        if (cmd_accept) begin
            cmd_d.write = cmd_write_i;
            cmd_d.addr  = cmd_addr_i;
            cmd_d.wdata = cmd_write_i ? cmd_wdata_i : '0;
            cmd_d.strb  = cmd_write_i ? cmd_strb_i : '0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d = SETUP;
                    psel_d  = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cmd_q.write;
                    rsp_rdata_d = cmd_q.write ? '0 : prdata_i;
                    rsp_err_d   = 1'b0;
                    if (cmd_q.write) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end else begin
                        rd_count_d = rd_count_q + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cmd_q.write;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (cmd_accept) begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = cmd_q.write;
    assign paddr_o     = cmd_q.addr;
    assign pwdata_o    = cmd_q.wdata;
    assign pstrb_o     = cmd_q.strb;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign rd_count_o  = rd_count_q;
    assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_matmul_apb_requester.sv
// Self-checking bench for matmul_apb_requester: directed vector table, hand-written
// stall/reset sequences and a randomized run against a transaction-level model.
module tb_matmul_apb_requester;

    localparam int AW = 16;
    localparam int BW = 32;
    localparam int SW = BW / 8;
    localparam int CW = 16;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_write_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [BW-1:0] cmd_wdata_i = '0;
    logic [SW-1:0] cmd_strb_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b1;
    logic          rsp_write_o;
    logic [BW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          psel_o, penable_o, pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [BW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready_i;
    logic [BW-1:0] prdata_i;
    logic [CW-1:0] rd_count_o, wr_count_o;

    initial forever #5 clk_i = ~clk_i;

    matmul_apb_requester #(
        .DATA_WIDTH(16), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(2),
        .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .prdata_i(prdata_i),
        .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
    );

    // Expected bus transfer / response, one record per command.
    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [BW-1:0] rdata;
        bit            err;
    } xfer_t;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        int            ws;
        logic [BW-1:0] prdata;
        int            exp_lat;
        logic [BW-1:0] exp_rdata;
    } vec_t;

    xfer_t         exp_apb[$];
    xfer_t         exp_rsp[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            cur_ws = 0;
    logic [BW-1:0] cur_prdata = '0;
    bit            rr_rand = 1'b0;
    logic [CW-1:0] model_rd = '0;
    logic [CW-1:0] model_wr = '0;
    int            setup_cyc = 0;
    int            pen_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(negedge clk_i);
        if (rr_rand) rsp_ready_i = ($urandom_range(0, 3) != 0);
    end

    // APB completer: pready is deliberately high in SETUP (must be ignored) and
    // prdata is junk except in the completing ACCESS cycle.
    initial begin
        automatic int acc_k = 0;
        pready_i = 1'b0;
        prdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (psel_o && !penable_o) begin
                pready_i = 1'b1;
                prdata_i = $urandom;
                acc_k    = 0;
            end else if (psel_o && penable_o) begin
                pready_i = (acc_k >= cur_ws);
                prdata_i = pready_i ? cur_prdata : BW'($urandom);
                acc_k++;
            end else begin
                pready_i = 1'($urandom_range(0, 1));
                prdata_i = $urandom;
                acc_k    = 0;
            end
        end
    end

    // Bus monitor: stability from SETUP through ACCESS, and transfer contents.
    initial begin
        logic [AW-1:0] s_addr;
        logic [BW-1:0] s_wdata;
        logic [SW-1:0] s_strb;
        logic          s_write;
        xfer_t         e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && psel_o && !penable_o) begin
                setup_cyc = cyc;
                pen_cnt   = 0;
                s_addr    = paddr_o;
                s_wdata   = pwdata_o;
                s_strb    = pstrb_o;
                s_write   = pwrite_o;
            end else if (rst_ni && psel_o && penable_o) begin
                pen_cnt++;
                check("apb_stable", {pwrite_o, paddr_o, pwdata_o, pstrb_o},
                      {s_write, s_addr, s_wdata, s_strb});
                if (pready_i) begin
                    if (exp_apb.size() == 0) begin
                        bound_expired("apb_unexpected_transfer");
                    end else begin
                        e = exp_apb.pop_front();
                        check("apb_write", pwrite_o, e.write);
                        check("apb_addr", paddr_o, e.addr);
                        check("apb_wdata", pwdata_o, e.wdata);
                        check("apb_strb", pstrb_o, e.strb);
                    end
                end
            end
        end
    end

    // Response scoreboard and counter model.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && rsp_valid_o && rsp_ready_i) begin
                if (exp_rsp.size() == 0) begin
                    bound_expired("rsp_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_write", rsp_write_o, e.write);
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                    check("rsp_err", rsp_err_o, e.err);
                    if (!e.err) begin
                        if (e.write) model_wr++;
                        else model_rd++;
                    end
                    check("rd_count", rd_count_o, model_rd);
                    check("wr_count", wr_count_o, model_wr);
                end
            end
        end
    end

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                        input logic [SW-1:0] s, input int ws, input logic [BW-1:0] prd,
                        input bit err, output int acc);
        automatic int n = 0;
        xfer_t x;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
        while (!cmd_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) begin
            bound_expired("cmd_accept");
            cmd_valid_i = 1'b0;
            acc = cyc;
            return;
        end
        acc        = cyc;
        cur_ws     = ws;
        cur_prdata = prd;
        x.write = w;
        x.addr  = a;
        x.wdata = w ? d : '0;
        x.strb  = w ? s : '0;
        x.rdata = (w || err) ? '0 : prd;
        x.err   = err;
        if (!err) exp_apb.push_back(x);
        exp_rsp.push_back(x);
        tick();
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = $urandom;
        cmd_strb_i  = SW'($urandom);
    endtask

    task automatic wait_rsp(input string name);
        automatic int n = 0;
        while (!rsp_valid_o && n < 300) begin
            tick();
            n++;
        end
        if (!rsp_valid_o) bound_expired(name);
    endtask

    task automatic wait_drain();
        automatic int n = 0;
        while ((exp_rsp.size() != 0 || rsp_valid_o) && n < 2000) begin
            tick();
            n++;
        end
        if (exp_rsp.size() != 0 || rsp_valid_o) bound_expired("drain");
    endtask

    initial begin
        vec_t vecs[6];
        int   acc;
        int   prev_acc;

        vecs[0] = '{1'b1, 16'h0010, 32'h0000_ABCD, 4'hF, 0, 32'h0, 3, 32'h0};
        vecs[1] = '{1'b0, 16'h0100, 32'hDEAD_BEEF, 4'hF, 3, 32'h1234_5678, 6, 32'h1234_5678};
        vecs[2] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 4'h3, 1, 32'h0, 4, 32'h0};
        vecs[3] = '{1'b0, 16'h0000, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 16'h0004, 32'h8000_0001, 4'h8, 5, 32'h5555_5555, 8, 32'h0};
        vecs[5] = '{1'b0, 16'h0020, 32'h0, 4'h0, 7, 32'hA5A5_0F0F, 10, 32'hA5A5_0F0F};

        // Reset state, observed while reset is held.
        #1;
        check("reset_cmd_ready", cmd_ready_o, 1'b1);
        check("reset_bus", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}, '0);
        check("reset_rsp", {rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o}, '0);
        check("reset_counts", {rd_count_o, wr_count_o}, '0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check("idle_cmd_ready", cmd_ready_o, 1'b1);

        // Directed vectors with latency and bus-phase timing.
        foreach (vecs[i]) begin
            send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].ws, vecs[i].prdata, 1'b0, acc);
            wait_rsp("vec_rsp");
            check($sformatf("vec%0d_latency", i), cyc - acc, vecs[i].exp_lat);
            check($sformatf("vec%0d_psel_cycle", i), setup_cyc - acc, 1);
            check($sformatf("vec%0d_penable_cycles", i), pen_cnt, vecs[i].exp_lat - 2);
            check($sformatf("vec%0d_rdata", i), rsp_rdata_o, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rsp_write", i), rsp_write_o, vecs[i].write);
            tick();
        end
        wait_drain();
        check("vec_wr_count", wr_count_o, 16'd3);
        check("vec_rd_count", rd_count_o, 16'd3);

        // Eight back-to-back reads: one accept every three cycles.
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, AW'($urandom), $urandom, SW'($urandom), 0, $urandom, 1'b0, acc);
            if (i > 0) check("b2b_spacing", acc - prev_acc, 3);
            prev_acc = acc;
        end
        wait_drain();
        check("b2b_rd_count", rd_count_o, model_rd);

        // Response back-pressure with a second command pending.
        rsp_ready_i = 1'b0;
        send(1'b1, 16'h0044, 32'hCAFE_F00D, 4'h5, 0, 32'h0, 1'b0, acc);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 16'h0048;
        cmd_strb_i  = 4'hF;
        wait_rsp("stall_rsp");
        for (int k = 0; k < 5; k++) begin
            check("stall_cmd_ready", cmd_ready_o, 1'b0);
            check("stall_rsp_hold", {rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o},
                  {1'b1, 1'b1, 32'h0, 1'b0});
            tick();
        end
        begin
            xfer_t x;
            rsp_ready_i = 1'b1;
            #1;
            check("stall_release_cmd_ready", cmd_ready_o, 1'b1);
            acc        = cyc;
            cur_ws     = 1;
            cur_prdata = 32'h0BAD_CAFE;
            x = '{1'b0, 16'h0048, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0};
            exp_apb.push_back(x);
            exp_rsp.push_back(x);
            tick();
            cmd_valid_i = 1'b0;
            wait_rsp("stall_second_rsp");
            check("stall_second_latency", cyc - acc, 4);
            check("stall_second_rdata", rsp_rdata_o, 32'h0BAD_CAFE);
        end
        wait_drain();

        // Randomized traffic with random response back-pressure.
        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                 $urandom_range(0, 4), $urandom, 1'b0, acc);
        end
        rr_rand = 1'b0;
        tick();
        rsp_ready_i = 1'b1;
        wait_drain();
        check("rand_rd_count", rd_count_o, model_rd);
        check("rand_wr_count", wr_count_o, model_wr);

`ifdef MATMUL_APB_TIMEOUT_EN
        // Watchdog abort, then pready landing exactly on the limit cycle.
        send(1'b0, 16'h0200, 32'h0, 4'h0, 1000, 32'h7777_7777, 1'b1, acc);
        wait_rsp("to_rsp");
        check("to_latency", cyc - acc, 2 + TO);
        check("to_penable_cycles", pen_cnt, TO);
        check("to_err", rsp_err_o, 1'b1);
        check("to_rdata", rsp_rdata_o, 32'h0);
        tick();
        wait_drain();
        check("to_rd_count", rd_count_o, model_rd);
        send(1'b0, 16'h0204, 32'h0, 4'h0, TO - 1, 32'h3141_5926, 1'b0, acc);
        wait_rsp("to_limit_rsp");
        check("to_limit_err", rsp_err_o, 1'b0);
        check("to_limit_rdata", rsp_rdata_o, 32'h3141_5926);
        wait_drain();
`endif

        // Asynchronous reset during ACCESS.
        send(1'b0, 16'h0300, 32'h0, 4'h0, 6, 32'h1111_2222, 1'b0, acc);
        begin
            automatic int n = 0;
            while (!penable_o && n < 20) begin
                tick();
                n++;
            end
            if (!penable_o) bound_expired("reset_wait_access");
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_psel_penable", {psel_o, penable_o}, 2'b00);
        check("async_reset_rsp_valid", rsp_valid_o, 1'b0);
        exp_apb.delete();
        exp_rsp.delete();
        model_rd = '0;
        model_wr = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_reset_cmd_ready", cmd_ready_o, 1'b1);
        check("post_reset_counts", {rd_count_o, wr_count_o}, '0);
        check("post_reset_bus", {psel_o, penable_o, rsp_valid_o}, 3'b000);
        send(1'b1, 16'h0010, 32'h0000_ABCD, 4'hF, 0, 32'h0, 1'b0, acc);
        wait_rsp("post_reset_rsp");
        check("post_reset_latency", cyc - acc, 3);
        wait_drain();
        check("post_reset_wr_count", wr_count_o, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "global timeout");
    end

endmodule
